// File: rtl/imm_ext_arbiter.sv
// Round-robin shared 16->32 immediate extender with a single registered output slot.
// Build option: define IMM_EXT_ERR_EN to flag reserved mode 11 via out_err (else it sign-extends).
module imm_ext_arbiter #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [IMM_W-1:0]  req0_imm,
    input  logic [1:0]        req0_mode,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [IMM_W-1:0]  req1_imm,
    input  logic [1:0]        req1_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    output logic              out_err
);

    localparam int unsigned PAD_W = DATA_W - IMM_W;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_id_q,    out_id_d;
    logic              rr_last_q,   rr_last_d;
    logic              slot_free;
    logic              grant;
    logic              accept;
    logic [IMM_W-1:0]  sel_imm;
    logic [1:0]        sel_mode;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;

    // Arbitration: contention goes to the requester not served last.
    always_comb begin
        slot_free  = !out_valid_q || out_ready;
        grant      = req1_valid && (!req0_valid || !rr_last_q);
        req0_ready = slot_free && req0_valid && !grant;
        req1_ready = slot_free && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        sel_imm    = grant ? req1_imm  : req0_imm;
        sel_mode   = grant ? req1_mode : req0_mode;
    end

    // Immediate extension for the granted request.
    always_comb begin
        ext_data = {{PAD_W{sel_imm[IMM_W-1]}}, sel_imm};
        ext_err  = 1'b0;
        case (sel_mode)
            2'b01: ext_data = {{PAD_W{1'b0}}, sel_imm};
            2'b10: ext_data = {sel_imm, {PAD_W{1'b0}}};
`ifdef IMM_EXT_ERR_EN
            2'b11: begin
                ext_data = '0;
                ext_err  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Output slot: a drain clears valid, an accept (re)fills it on the same edge.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        rr_last_d   = rr_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = ext_data;
            out_id_d    = grant;
            rr_last_d   = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            rr_last_q   <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            rr_last_q   <= rr_last_d;
        end
    end

`ifdef IMM_EXT_ERR_EN
    logic out_err_q, out_err_d;

    always_comb begin
        out_err_d = out_err_q;
        if (accept) out_err_d = ext_err;
    end

    always_ff @(posedge clk) begin
        if (rst) out_err_q <= 1'b0;
        else     out_err_q <= out_err_d;
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter; honours IMM_EXT_ERR_EN for the reserved-mode step.
module tb_imm_ext_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_imm;
    logic [1:0]  req0_mode;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_imm;
    logic [1:0]  req1_mode;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_id, out_err;

    int n_tests = 0;
    int n_fail  = 0;

    imm_ext_arbiter #(.IMM_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_imm(req0_imm), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_imm(req1_imm), .req1_mode(req1_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic id);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  out_data,       d);
        chk({tag, ".id"},    32'(out_id),    32'(id));
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, ".rdy0"}, 32'(req0_ready), 32'(r0));
        chk({tag, ".rdy1"}, 32'(req1_ready), 32'(r1));
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        req0_valid = 1'b0; req0_imm = '0; req0_mode = '0;
        req1_valid = 1'b0; req1_imm = '0; req1_mode = '0;
        tick(); tick();
        rst = 1'b0;
        chk_out("reset", 1'b0, 32'h0, 1'b0);
        chk("reset.err", 32'(out_err), 32'h0);

        // 1: single req0 sign-extend, one-cycle latency
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_imm = 16'h7abc; req0_mode = 2'b00;
        chk_rdy("t1", 1'b1, 1'b0);
        tick(); req0_valid = 1'b0;
        chk_out("t1", 1'b1, 32'h0000_7abc, 1'b0);

        // 2: req1 in each legal mode, back to back
        req1_valid = 1'b1; req1_imm = 16'h8abc; req1_mode = 2'b00;
        chk_rdy("t2s", 1'b0, 1'b1);
        tick();
        chk_out("t2s", 1'b1, 32'hffff_8abc, 1'b1);
        req1_mode = 2'b01;
        tick();
        chk_out("t2z", 1'b1, 32'h0000_8abc, 1'b1);
        req1_imm = 16'h1234; req1_mode = 2'b10;
        tick(); req1_valid = 1'b0;
        chk_out("t2l", 1'b1, 32'h1234_0000, 1'b1);
        tick();
        chk_out("drain", 1'b0, 32'h1234_0000, 1'b1);

        // 3: continuous contention alternates, pointer last granted req1
        req0_valid = 1'b1; req0_imm = 16'h0001; req0_mode = 2'b01;
        req1_valid = 1'b1; req1_imm = 16'h0002; req1_mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            chk_rdy("t3", (i % 2) == 0, (i % 2) == 1);
            tick();
            chk_out("t3", 1'b1, (i % 2) == 1 ? 32'h2 : 32'h1, 1'((i % 2) == 1));
        end

        // 4: backpressure freezes the slot; release accepts the pending req0
        out_ready = 1'b0; req0_imm = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            chk_rdy("t4bp", 1'b0, 1'b0);
            tick();
            chk_out("t4bp", 1'b1, 32'h2, 1'b1);
        end
        out_ready = 1'b1;
        chk_rdy("t4rel", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk_out("t4rel", 1'b1, 32'h3, 1'b0);

        // 5: reset with a held result, then contention goes to req0
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("t5rst", 1'b0, 32'h0, 1'b0);
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_imm = 16'h0005; req0_mode = 2'b00;
        req1_valid = 1'b1; req1_imm = 16'h0006; req1_mode = 2'b00;
        chk_rdy("t5arb", 1'b1, 1'b0);
        tick();
        req1_valid = 1'b0;
        chk_out("t5arb", 1'b1, 32'h5, 1'b0);

        // 6: reserved mode, then a legal result clears the flag
        req0_imm = 16'hffff; req0_mode = 2'b11;
        tick();
`ifdef IMM_EXT_ERR_EN
        chk_out("t6res", 1'b1, 32'h0, 1'b0);
        chk("t6res.err", 32'(out_err), 32'h1);
`else
        chk_out("t6res", 1'b1, 32'hffff_ffff, 1'b0);
        chk("t6res.err", 32'(out_err), 32'h0);
`endif
        req0_mode = 2'b01;
        tick();
        req0_valid = 1'b0;
        chk_out("t6ok", 1'b1, 32'h0000_ffff, 1'b0);
        chk("t6ok.err", 32'(out_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
